xif_mac_coproc: RTL

Coprocessor on the responder side of the CORE-V eXtension interface, driven by the CPU top's compressed, issue, commit and result ports. It accepts custom-0 multiply-accumulate instructions and buffers them until the CPU commits or kills them. Committed instructions execute in order against a private 64-bit accumulator, and each produces a register writeback. The memory and memory-result interfaces are not implemented; the integrating top ties `mem_valid` low.

---
 rtl/xif_mac_coproc.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/xif_mac_coproc.sv
// CORE-V-XIF responder: custom-0 MAC / RDHI / CLR against a private 64-bit accumulator.
// Build option XMAC_SAT_EN: MAC saturates on signed overflow instead of wrapping.
module xif_mac_coproc #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned X_NUM_RS   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // compressed interface
    input  logic                   compressed_valid,
    output logic                   compressed_ready,
    input  logic [15:0]            compressed_req_instr,
    output logic [31:0]            compressed_resp_instr,
    output logic                   compressed_resp_accept,
    // issue interface
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [31:0]            issue_req_instr,
    input  logic [X_ID_WIDTH-1:0]  issue_req_id,
    input  logic [X_NUM_RS*32-1:0] issue_req_rs,
    input  logic [X_NUM_RS-1:0]    issue_req_rs_valid,
    output logic                   issue_resp_accept,
    output logic                   issue_resp_writeback,
    output logic                   issue_resp_dualwrite,
    output logic [2:0]             issue_resp_dualread,
    output logic                   issue_resp_loadstore,
    output logic                   issue_resp_ecswrite,
    output logic                   issue_resp_exc,
    // commit interface
    input  logic                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]  commit_id,
    input  logic                   commit_kill,
    // result interface
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [X_ID_WIDTH-1:0]  result_id,
    output logic [31:0]            result_data,
    output logic [4:0]             result_rd,
    output logic                   result_we,
    output logic [5:0]             result_ecsdata,
    output logic [2:0]             result_ecswe,
    output logic                   result_exc,
    output logic [5:0]             result_exccode,
    output logic                   result_err,
    output logic                   result_dbg
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_MAC      = 3'b000;
    localparam logic [2:0] F3_RDHI     = 3'b001;
    localparam logic [2:0] F3_CLR      = 3'b010;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic [31:0]           rs1;
        logic [31:0]           rs2;
    } entry_t;

    state_e                state_q, state_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      committed_q, committed_d;
    entry_t                mem_q [DEPTH];
    logic [63:0]           acc_q, acc_d;
    logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [31:0]           res_data_q, res_data_d;
    logic [4:0]            res_rd_q, res_rd_d;
    logic                  res_we_q, res_we_d;

    logic [AW-1:0]         head_idx, tail_idx;
    logic [2:0]            issue_funct3;
    logic [4:0]            issue_rd;
    logic                  match, full;
    logic                  issue_fire, issue_commit_hit, issue_write;
    entry_t                head_e;
    logic                  head_ready, head_skip, pop;
    logic [63:0]           op_a, op_b, product, mac_sum, mac_result;
    logic [63:0]           exec_acc;
    logic [31:0]           exec_data;
    logic                  unused_inputs;

    // ------------------------------------------------------------------
    // Issue decode and handshake
    // ------------------------------------------------------------------
    assign issue_funct3 = issue_req_instr[14:12];
    assign issue_rd     = issue_req_instr[11:7];
    assign match        = (issue_req_instr[6:0] == OPC_CUSTOM0)
                       && (issue_req_instr[31:25] == 7'b0)
                       && ((issue_funct3 == F3_MAC) || (issue_funct3 == F3_RDHI)
                           || (issue_funct3 == F3_CLR));

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    // Slots between head and tail stay allocated until the head walks past them,
    // so fullness is pointer distance rather than a popcount of valid bits.
    assign full     = ((tail_q - head_q) == PW'(DEPTH));

    assign issue_ready          = !full && (!match || (issue_req_rs_valid[1:0] == 2'b11));
    assign issue_resp_accept    = match;
    assign issue_resp_writeback = match && (issue_rd != 5'd0);
    assign issue_resp_dualwrite = 1'b0;
    assign issue_resp_dualread  = 3'b000;
    assign issue_resp_loadstore = 1'b0;
    assign issue_resp_ecswrite  = 1'b0;
    assign issue_resp_exc       = 1'b0;

    assign issue_fire       = issue_valid && issue_ready && match;
    assign issue_commit_hit = commit_valid && (commit_id == issue_req_id);
    assign issue_write      = issue_fire && !(issue_commit_hit && commit_kill);

    assign compressed_ready       = 1'b1;
    assign compressed_resp_accept = 1'b0;
    assign compressed_resp_instr  = 32'b0;

    assign unused_inputs = ^{compressed_valid, compressed_req_instr, issue_req_instr[24:15]};

    // ------------------------------------------------------------------
    // Execute datapath on the head entry
    // ------------------------------------------------------------------
    assign head_e     = mem_q[head_idx];
    assign head_ready = valid_q[head_idx] && committed_q[head_idx];
    assign head_skip  = (head_q != tail_q) && !valid_q[head_idx];

    // Low 64 bits of the sign-extended product equal the exact 32x32 signed product.
    assign op_a    = {{32{head_e.rs1[31]}}, head_e.rs1};
    assign op_b    = {{32{head_e.rs2[31]}}, head_e.rs2};
    assign product = op_a * op_b;
    assign mac_sum = acc_q + product;

`ifdef XMAC_SAT_EN
    logic mac_ovf;
    assign mac_ovf    = (acc_q[63] == product[63]) && (mac_sum[63] != acc_q[63]);
    assign mac_result = !mac_ovf ? mac_sum
                      : (acc_q[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
`else
    assign mac_result = mac_sum;
`endif

    always_comb begin
        exec_acc  = acc_q;
        exec_data = acc_q[31:0];
        case (head_e.funct3)
            F3_MAC: begin
                exec_acc  = mac_result;
                exec_data = mac_result[31:0];
            end
            F3_RDHI: exec_data = acc_q[63:32];
            default: exec_acc  = 64'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_ready) begin
                    pop     = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (result_ready) begin
                    if (head_ready) pop     = 1'b1;
                    else            state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        res_id_d   = res_id_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        res_we_d   = res_we_q;
        if (pop) begin
            acc_d      = exec_acc;
            res_id_d   = head_e.id;
            res_data_d = exec_data;
            res_rd_d   = head_e.rd;
            res_we_d   = (head_e.rd != 5'd0);
        end
    end

    // ------------------------------------------------------------------
    // Buffer bookkeeping: commit/kill search, allocate, pop, skip
    // ------------------------------------------------------------------
    always_comb begin
        valid_d     = valid_q;
        committed_d = committed_q;
        head_d      = head_q;
        tail_d      = tail_q;
        if (commit_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && (mem_q[i].id == commit_id)) begin
                    if (commit_kill) valid_d[i]     = 1'b0;
                    else             committed_d[i] = 1'b1;
                end
            end
        end
        if (issue_write) begin
            valid_d[tail_idx]     = 1'b1;
            committed_d[tail_idx] = issue_commit_hit;
            tail_d                = tail_q + PW'(1);
        end
        // Pop last so a stray commit/kill aimed at the departing entry has no effect.
        if (pop) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PW'(1);
        end else if (head_skip) begin
            head_d = head_q + PW'(1);
        end
    end

    // NOTE: the payload RAM carries no reset; valid_q alone marks live slots,
    // which keeps the storage free of reset fan-out.
    always_ff @(posedge clk_i) begin
        if (issue_write) begin
            mem_q[tail_idx] <= '{id:     issue_req_id,
                                 rd:     issue_rd,
                                 funct3: issue_funct3,
                                 rs1:    issue_req_rs[31:0],
                                 rs2:    issue_req_rs[63:32]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            committed_q <= '0;
            acc_q       <= '0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
            acc_q       <= acc_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_we_q    <= res_we_d;
        end
    end

    assign result_valid   = (state_q == S_RESP);
    assign result_id      = res_id_q;
    assign result_data    = res_data_q;
    assign result_rd      = res_rd_q;
    assign result_we      = res_we_q;
    assign result_ecsdata = 6'b0;
    assign result_ecswe   = 3'b0;
    assign result_exc     = 1'b0;
    assign result_exccode = 6'b0;
    assign result_err     = 1'b0;
    assign result_dbg     = 1'b0;

endmodule
